ifetch_unit: RTL

Instruction fetch stage of the CPU: owns the program counter, issues word reads to instruction memory over a req/ready handshake, and presents one fetched instruction at a time to the instruction decoder together with its PC and PC+4. It is the producer of the decoder's instruction input and the consumer of the resolved jump/branch target. A one-entry output buffer lets it sustain one instruction per cycle with zero-wait memory while absorbing decoder stalls and redirects.

---
 rtl/ifetch_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over a
// req/ready handshake and holds one fetched instruction for the decoder.
//
// Handshakes:
//   imem: imem_req/imem_addr are held stable from the cycle imem_req rises
//         until the cycle imem_ready is seen high; a word transfers on
//         imem_req && imem_ready, and imem_req never depends on imem_ready.
//   decoder: the held instruction transfers on ins_valid_o && !stall_i;
//         redirect_i discards it instead of transferring it.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        sys_clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] ins_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        ins_valid_o,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_q, drain_d;
    logic        load_buf;
    logic [31:0] target;
    logic [31:0] pc_inc;
    logic        redirect_lsb_unused;

    // Targets are always word aligned; the low bits of redirect_pc_i are ignored.
    assign target              = {redirect_pc_i[31:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc_i[1:0];
    assign pc_inc              = pc_q + 32'd4;

    assign ins_valid_o = (state_q == ST_FULL);
    assign dbg_state   = state_q;

    // Next-state, next-PC and memory request decode.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drain_d   = drain_q;
        load_buf  = 1'b0;
        imem_req  = 1'b0;
        imem_addr = pc_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (redirect_i) begin
                    pc_d = target;
                    // An unfinished request must still complete; remember
                    // its address and discard the word when it arrives.
                    if (!imem_ready) begin
                        drain_d = pc_q;
                        state_d = ST_DRAIN;
                    end
                end else if (imem_ready) begin
                    load_buf = 1'b1;
                    pc_d     = pc_inc;
                    state_d  = ST_FULL;
                end
            end
            ST_FULL: begin
                if (redirect_i) begin
                    pc_d    = target;
                    state_d = ST_FETCH;
                end else if (!stall_i) begin
                    // Buffer is consumed this cycle, so it can take the next
                    // word in the same edge if memory answers at once.
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        load_buf = 1'b1;
                        pc_d     = pc_inc;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = drain_q;
                if (redirect_i) begin
                    pc_d = target;
                end
                if (imem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, PC and output buffer registers.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= START_PC;
            drain_q    <= 32'd0;
            ins_o      <= 32'd0;
            pc_o       <= 32'd0;
            pc_plus4_o <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drain_q <= drain_d;
            if (load_buf) begin
                ins_o      <= imem_rdata;
                pc_o       <= pc_q;
                pc_plus4_o <= pc_inc;
            end
        end
    end

endmodule
